program_counter_unit: RTL and testbench

PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

---
 rtl/program_counter_unit_pkg.sv | 21 ++
 rtl/program_counter_unit_ras.sv | 55 +++++
 rtl/program_counter_unit.sv | 147 ++++++++++++++
 tb/tb_program_counter_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/program_counter_unit_pkg.sv
// Shared definitions for the program counter unit: widths, return stack
// depth, the pc_control encoding and the bit positions of the ALU flags.
package program_counter_unit_pkg;

  localparam int PC_WIDTH  = 16;
  localparam int RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_JUMP = 2'b01,
    PC_CALL = 2'b10,
    PC_RET  = 2'b11
  } pc_ctrl_e;

  // Flag register layout {O,S,C,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 3;

endpackage

// File: rtl/program_counter_unit_ras.sv
// return_address_stack: RAS_DEPTH-entry LIFO of return addresses.
// Ports:
//   clk, reset_n   clock and synchronous active-low reset (clears pointer only)
//   push, push_data  push a return address (ignored when full)
//   pop              discard the top entry (ignored when empty)
//   top_data         current top entry (valid when !empty)
//   full, empty      occupancy status
module return_address_stack
  import program_counter_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push,
  input  logic [PC_WIDTH-1:0] push_data,
  input  logic                pop,
  output logic [PC_WIDTH-1:0] top_data,
  output logic                full,
  output logic                empty
);

  localparam int SP_W = $clog2(RAS_DEPTH) + 1;
  localparam logic [SP_W-1:0] DEPTH_V = SP_W'(RAS_DEPTH);

  logic [SP_W-1:0]     sp_q, sp_d;
  logic [SP_W-1:0]     sp_m1;
  logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PC_WIDTH-1:0] mem_d [RAS_DEPTH];

  assign full     = (sp_q == DEPTH_V);
  assign empty    = (sp_q == '0);
  assign sp_m1    = sp_q - 1'b1;
  assign top_data = mem_q[sp_m1[SP_W-2:0]];

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (push && !full) begin
      mem_d[sp_q[SP_W-2:0]] = push_data;
      sp_d = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) sp_q <= '0;
    else          sp_q <= sp_d;
  end

  // Contents are only meaningful below the pointer, so they need no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/program_counter_unit.sv
// program_counter_unit: instruction address generator with conditional
// jumps, call/return through a return stack, and an ALU flags register.
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   pc_increment_control      1 = advance/redirect this cycle, 0 = hold
//   pc_control                PC_SEQ / PC_JUMP / PC_CALL / PC_RET
//   jump_address              target for jump and call
//   jump_*_control            condition selects (OR-ed; none = unconditional)
//   flags_write_enable, alu_flags  flags register load
//   pc, flags, branch_taken   registered outputs
//   stack_overflow/underflow  sticky stack error indicators
module program_counter_unit
  import program_counter_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pc_increment_control,
  input  logic [1:0]          pc_control,
  input  logic [PC_WIDTH-1:0] jump_address,
  input  logic                jump_zero_control,
  input  logic                jump_below_control,
  input  logic                jump_below_equal_control,
  input  logic                jump_above_control,
  input  logic                jump_above_equal_control,
  input  logic                jump_greater_control,
  input  logic                jump_greater_equal_control,
  input  logic                jump_less_control,
  input  logic                jump_less_equal_control,
  input  logic                flags_write_enable,
  input  logic [3:0]          alu_flags,
  output logic [PC_WIDTH-1:0] pc,
  output logic [3:0]          flags,
  output logic                branch_taken,
  output logic                stack_overflow,
  output logic                stack_underflow
);

  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [3:0]          flags_q, flags_d;
  logic                branch_taken_q, branch_taken_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;

  logic                ras_push, ras_pop, ras_full, ras_empty;
  logic [PC_WIDTH-1:0] ras_top;

  pc_ctrl_e ctrl;
  logic     f_z, f_c, f_s, f_o;
  logic [8:0] sel, cond;
  logic       jump_taken;

  assign ctrl   = pc_ctrl_e'(pc_control);
  assign pc_inc = pc_q + 1'b1;

  // Conditions look at the registered flags so a same-cycle flags write
  // only influences later instructions.
  assign f_z = flags_q[FLAG_Z];
  assign f_c = flags_q[FLAG_C];
  assign f_s = flags_q[FLAG_S];
  assign f_o = flags_q[FLAG_O];

  assign sel = {jump_less_equal_control, jump_less_control,
                jump_greater_equal_control, jump_greater_control,
                jump_above_equal_control, jump_above_control,
                jump_below_equal_control, jump_below_control,
                jump_zero_control};

  assign cond = {f_z | (f_s != f_o),
                 f_s != f_o,
                 f_s == f_o,
                 !f_z & (f_s == f_o),
                 !f_c,
                 !f_c & !f_z,
                 f_c | f_z,
                 f_c,
                 f_z};

  assign jump_taken = (sel == '0) || ((sel & cond) != '0);

  always_comb begin
    pc_d           = pc_q;
    flags_d        = flags_write_enable ? alu_flags : flags_q;
    branch_taken_d = 1'b0;
    ovf_d          = ovf_q;
    unf_d          = unf_q;
    ras_push       = 1'b0;
    ras_pop        = 1'b0;
    if (pc_increment_control) begin
      unique case (ctrl)
        PC_SEQ: pc_d = pc_inc;
        PC_JUMP: begin
          pc_d           = jump_taken ? jump_address : pc_inc;
          branch_taken_d = jump_taken;
        end
        PC_CALL: begin
          pc_d           = jump_address;
          branch_taken_d = 1'b1;
          if (ras_full) ovf_d    = 1'b1;
          else          ras_push = 1'b1;
        end
        PC_RET: begin
          if (ras_empty) begin
            unf_d = 1'b1;
            pc_d  = pc_inc;
          end else begin
            ras_pop        = 1'b1;
            pc_d           = ras_top;
            branch_taken_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q           <= '0;
      flags_q        <= '0;
      branch_taken_q <= 1'b0;
      ovf_q          <= 1'b0;
      unf_q          <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      flags_q        <= flags_d;
      branch_taken_q <= branch_taken_d;
      ovf_q          <= ovf_d;
      unf_q          <= unf_d;
    end
  end

  return_address_stack u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ras_push),
    .push_data (pc_inc),
    .pop       (ras_pop),
    .top_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign pc              = pc_q;
  assign flags           = flags_q;
  assign branch_taken    = branch_taken_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_program_counter_unit.sv
module tb_program_counter_unit;
  import program_counter_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inc;
  logic [1:0]  ctrl;
  logic [15:0] addr;
  logic [8:0]  sel;
  logic        fwe;
  logic [3:0]  af;
  logic [15:0] pc;
  logic [3:0]  flags;
  logic        bt, ovf, unf;

  program_counter_unit dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .pc_increment_control       (inc),
    .pc_control                 (ctrl),
    .jump_address               (addr),
    .jump_zero_control          (sel[0]),
    .jump_below_control         (sel[1]),
    .jump_below_equal_control   (sel[2]),
    .jump_above_control         (sel[3]),
    .jump_above_equal_control   (sel[4]),
    .jump_greater_control       (sel[5]),
    .jump_greater_equal_control (sel[6]),
    .jump_less_control          (sel[7]),
    .jump_less_equal_control    (sel[8]),
    .flags_write_enable         (fwe),
    .alu_flags                  (af),
    .pc                         (pc),
    .flags                      (flags),
    .branch_taken               (bt),
    .stack_overflow             (ovf),
    .stack_underflow            (unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [3:0]  flags;
    logic        bt, ovf, unf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [8:0] S_NONE = 9'd0;
  localparam logic [8:0] S_Z    = 9'b000000001;
  localparam logic [8:0] S_B    = 9'b000000010;
  localparam logic [8:0] S_BE   = 9'b000000100;
  localparam logic [8:0] S_A    = 9'b000001000;
  localparam logic [8:0] S_AE   = 9'b000010000;
  localparam logic [8:0] S_G    = 9'b000100000;
  localparam logic [8:0] S_GE   = 9'b001000000;
  localparam logic [8:0] S_L    = 9'b010000000;
  localparam logic [8:0] S_LE   = 9'b100000000;

  // Monitor: every cycle the outputs are presented; compare against the
  // oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (pc !== e.pc) begin
        errors++;
        $display("FAIL %s pc: got %h expected %h", e.name, pc, e.pc);
      end
      checks++;
      if (flags !== e.flags) begin
        errors++;
        $display("FAIL %s flags: got %b expected %b", e.name, flags, e.flags);
      end
      checks++;
      if (bt !== e.bt) begin
        errors++;
        $display("FAIL %s branch_taken: got %b expected %b", e.name, bt, e.bt);
      end
      checks++;
      if (ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s stack_overflow: got %b expected %b", e.name, ovf, e.ovf);
      end
      checks++;
      if (unf !== e.unf) begin
        errors++;
        $display("FAIL %s stack_underflow: got %b expected %b", e.name, unf, e.unf);
      end
    end
  end

  task automatic step(input string name, input logic rst_n, input logic i,
                      input logic [1:0] c, input logic [15:0] a,
                      input logic [8:0] s, input logic w, input logic [3:0] f,
                      input logic [15:0] e_pc, input logic [3:0] e_fl,
                      input logic e_bt, input logic e_ovf, input logic e_unf);
    exp_t e;
    @(negedge clk);
    reset_n = rst_n; inc = i; ctrl = c; addr = a; sel = s; fwe = w; af = f;
    e.name = name; e.pc = e_pc; e.flags = e_fl;
    e.bt = e_bt; e.ovf = e_ovf; e.unf = e_unf;
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; inc = 1'b0; ctrl = 2'b00; addr = '0; sel = '0; fwe = 1'b0; af = '0;

    //          name        rst  inc ctrl      addr      sel     fwe af       pc        fl    bt ov un
    step("reset",          0,   1, PC_SEQ,  16'h0000, S_NONE, 0, 4'h0, 16'h0000, 4'h0, 0, 0, 0);
    step("seq1",           1,   1, PC_SEQ,  16'h0000, S_NONE, 0, 4'h0, 16'h0001, 4'h0, 0, 0, 0);
    step("seq2",           1,   1, PC_SEQ,  16'h0000, S_NONE, 0, 4'h0, 16'h0002, 4'h0, 0, 0, 0);
    step("seq3",           1,   1, PC_SEQ,  16'h0000, S_NONE, 0, 4'h0, 16'h0003, 4'h0, 0, 0, 0);
    step("jmp_uncond",     1,   1, PC_JUMP, 16'hFFFF, S_NONE, 0, 4'h0, 16'hFFFF, 4'h0, 1, 0, 0);
    step("wrap",           1,   1, PC_SEQ,  16'h0000, S_NONE, 0, 4'h0, 16'h0000, 4'h0, 0, 0, 0);
    step("fw_z",           1,   1, PC_SEQ,  16'h0000, S_NONE, 1, 4'h1, 16'h0001, 4'h1, 0, 0, 0);
    step("jz_taken",       1,   1, PC_JUMP, 16'h0040, S_Z,    0, 4'h0, 16'h0040, 4'h1, 1, 0, 0);
    step("fw_clr",         1,   1, PC_SEQ,  16'h0000, S_NONE, 1, 4'h0, 16'h0041, 4'h0, 0, 0, 0);
    step("jz_not",         1,   1, PC_JUMP, 16'h0040, S_Z,    0, 4'h0, 16'h0042, 4'h0, 0, 0, 0);
    step("jz_samecyc",     1,   1, PC_JUMP, 16'h0040, S_Z,    1, 4'h1, 16'h0043, 4'h1, 0, 0, 0);
    step("jz_after",       1,   1, PC_JUMP, 16'h0010, S_Z,    0, 4'h0, 16'h0010, 4'h1, 1, 0, 0);
    step("call_hold",      1,   0, PC_CALL, 16'h0100, S_NONE, 0, 4'h0, 16'h0010, 4'h1, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      step($sformatf("call%0d", k), 1, 1, PC_CALL, 16'h0100, S_NONE, 0, 4'h0,
           16'h0100, 4'h1, 1, 0, 0);
    step("call9_ovf",      1,   1, PC_CALL, 16'h0100, S_NONE, 0, 4'h0, 16'h0100, 4'h1, 1, 1, 0);
    step("ret_hold",       1,   0, PC_RET,  16'h0000, S_NONE, 0, 4'h0, 16'h0100, 4'h1, 0, 1, 0);
    for (int k = 1; k <= 7; k++)
      step($sformatf("ret%0d", k), 1, 1, PC_RET, 16'h0000, (k == 1) ? S_A : S_NONE,
           0, 4'h0, 16'h0101, 4'h1, 1, 1, 0);
    step("ret8",           1,   1, PC_RET,  16'h0000, S_NONE, 0, 4'h0, 16'h0011, 4'h1, 1, 1, 0);
    step("ret9_unf",       1,   1, PC_RET,  16'h0000, S_NONE, 0, 4'h0, 16'h0012, 4'h1, 0, 1, 1);
    step("rst_in_call",    0,   1, PC_CALL, 16'h0200, S_NONE, 1, 4'hF, 16'h0000, 4'h0, 0, 0, 0);
    step("ret_empty",      1,   1, PC_RET,  16'h0000, S_NONE, 0, 4'h0, 16'h0001, 4'h0, 0, 0, 1);
    step("reset2",         0,   1, PC_SEQ,  16'h0000, S_NONE, 0, 4'h0, 16'h0000, 4'h0, 0, 0, 0);
    step("fw_c",           1,   1, PC_SEQ,  16'h0000, S_NONE, 1, 4'h2, 16'h0001, 4'h2, 0, 0, 0);
    step("jb_taken",       1,   1, PC_JUMP, 16'h00A0, S_B,    0, 4'h0, 16'h00A0, 4'h2, 1, 0, 0);
    step("ja_not",         1,   1, PC_JUMP, 16'h00B0, S_A,    0, 4'h0, 16'h00A1, 4'h2, 0, 0, 0);
    step("jae_not",        1,   1, PC_JUMP, 16'h00B0, S_AE,   0, 4'h0, 16'h00A2, 4'h2, 0, 0, 0);
    step("jbe_taken",      1,   1, PC_JUMP, 16'h00C0, S_BE,   0, 4'h0, 16'h00C0, 4'h2, 1, 0, 0);
    step("fw_o",           1,   1, PC_SEQ,  16'h0000, S_NONE, 1, 4'h8, 16'h00C1, 4'h8, 0, 0, 0);
    step("jge_not",        1,   1, PC_JUMP, 16'h00D0, S_GE,   0, 4'h0, 16'h00C2, 4'h8, 0, 0, 0);
    step("jl_taken",       1,   1, PC_JUMP, 16'h00E0, S_L,    0, 4'h0, 16'h00E0, 4'h8, 1, 0, 0);
    step("jle_taken",      1,   1, PC_JUMP, 16'h00F0, S_LE,   0, 4'h0, 16'h00F0, 4'h8, 1, 0, 0);
    step("jg_not",         1,   1, PC_JUMP, 16'h0100, S_G,    0, 4'h0, 16'h00F1, 4'h8, 0, 0, 0);
    step("jor_taken",      1,   1, PC_JUMP, 16'h0300, S_Z|S_L,0, 4'h0, 16'h0300, 4'h8, 1, 0, 0);
    step("jor_not",        1,   1, PC_JUMP, 16'h0310, S_Z|S_G,0, 4'h0, 16'h0301, 4'h8, 0, 0, 0);
    step("fw_zero",        1,   1, PC_SEQ,  16'h0000, S_NONE, 1, 4'h0, 16'h0302, 4'h0, 0, 0, 0);
    step("ja_taken",       1,   1, PC_JUMP, 16'h0400, S_A,    0, 4'h0, 16'h0400, 4'h0, 1, 0, 0);
    step("jg_taken",       1,   1, PC_JUMP, 16'h0500, S_G,    0, 4'h0, 16'h0500, 4'h0, 1, 0, 0);
    step("call_sel_ign",   1,   1, PC_CALL, 16'h0600, S_Z,    0, 4'h0, 16'h0600, 4'h0, 1, 0, 0);
    step("seq_sel_ign",    1,   1, PC_SEQ,  16'h0700, S_NONE|S_B, 0, 4'h0, 16'h0601, 4'h0, 0, 0, 0);
    step("ret_ok",         1,   1, PC_RET,  16'h0000, S_NONE, 0, 4'h0, 16'h0501, 4'h0, 1, 0, 0);
    step("hold_fw",        1,   0, PC_JUMP, 16'h0800, S_NONE, 1, 4'h5, 16'h0501, 4'h5, 0, 0, 0);

    @(negedge clk);
    inc = 1'b0; fwe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
